// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stage-latch hold/flush and PC enable generator for load-use, branch and mem-wait hazards
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255,
  parameter int CNT_W            = 16
) (
  input  logic             stg_clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rd_memory,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_ena,
  output logic             ifid_ena,
  output logic             ifid_x,
  output logic             idex_ena,
  output logic             idex_x,
  output logic             exmem_ena,
  output logic             memwb_x,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, LU_STALL} state_t;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t            state, state_nxt;
  logic [2:0]        bub_cnt, bub_nxt;
  logic              ret_lu, ret_lu_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_inc;
  logic              mw, lu, flush_evt;

  assign mw = mem_req & ~mem_ready;
  assign lu = ex_rd_memory & (ex_rd != 5'd0) &
              ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  assign wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;

  always_comb begin
    pc_ena     = 1'b1;
    ifid_ena   = 1'b1;
    ifid_x     = 1'b0;
    idex_ena   = 1'b1;
    idex_x     = 1'b0;
    exmem_ena  = 1'b1;
    memwb_x    = 1'b0;
    state_nxt  = RUN;
    bub_nxt    = bub_cnt;
    ret_lu_nxt = 1'b0;
    flush_evt  = 1'b0;

    if (mw) begin
      // Freeze everything; remember whether a load-use stall must resume afterwards.
      pc_ena     = 1'b0;
      ifid_ena   = 1'b0;
      idex_ena   = 1'b0;
      exmem_ena  = 1'b0;
      memwb_x    = 1'b1;
      state_nxt  = MEM_WAIT;
      ret_lu_nxt = (state == MEM_WAIT) ? ret_lu : (state == LU_STALL);
    end else if (ex_branch_taken) begin
      ifid_x    = 1'b1;
      idex_x    = 1'b1;
      bub_nxt   = 3'd0;
      flush_evt = 1'b1;
    end else if (state == LU_STALL || (state == MEM_WAIT && ret_lu)) begin
      pc_ena    = 1'b0;
      ifid_ena  = 1'b0;
      idex_x    = 1'b1;
      bub_nxt   = (bub_cnt != 3'd0) ? bub_cnt - 3'd1 : 3'd0;
      state_nxt = (bub_cnt <= 3'd1) ? RUN : LU_STALL;
    end else if (lu) begin
      pc_ena    = 1'b0;
      ifid_ena  = 1'b0;
      idex_x    = 1'b1;
      bub_nxt   = 3'(LOAD_USE_BUBBLES - 1);
      state_nxt = (bub_nxt != 3'd0) ? LU_STALL : RUN;
    end

    if (reset) begin
      pc_ena    = 1'b0;
      ifid_ena  = 1'b0;
      ifid_x    = 1'b1;
      idex_ena  = 1'b0;
      idex_x    = 1'b1;
      exmem_ena = 1'b0;
      memwb_x   = 1'b1;
    end
  end

  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      state           <= RUN;
      bub_cnt         <= 3'd0;
      ret_lu          <= 1'b0;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_nxt;
      ret_lu  <= ret_lu_nxt;
      if (mw) begin
        wait_cnt <= wait_inc;
        if (MEM_TIMEOUT != 0 && wait_inc == WAIT_W'(MEM_TIMEOUT))
          mem_timeout_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_ena && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (flush_evt && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - table-driven bench for pipe_hazard_ctrl (3-bubble/timeout-8 and 1-bubble instances)
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] P_RUN = 7'b1101010;
  localparam logic [6:0] P_BR  = 7'b1111110;
  localparam logic [6:0] P_LU  = 7'b0001110;
  localparam logic [6:0] P_FRZ = 7'b0000001;
  localparam logic [6:0] P_RST = 7'b0010101;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] exp_a;
    logic [6:0] exp_b;
  } vec_t;

  logic stg_clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_rd_memory, ex_branch_taken, mem_req, mem_ready;

  logic pc_a, ifen_a, ifx_a, iden_a, idx_a, exen_a, mwx_a, err_a;
  logic pc_b, ifen_b, ifx_b, iden_b, idx_b, exen_b, mwx_b, err_b;
  logic [15:0] stall_a, flush_a, stall_b, flush_b;
  logic [6:0] out_a, out_b;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  assign out_a = {pc_a, ifen_a, ifx_a, iden_a, idx_a, exen_a, mwx_a};
  assign out_b = {pc_b, ifen_b, ifx_b, iden_b, idx_b, exen_b, mwx_b};

  always #5 stg_clk = ~stg_clk;

  pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(8), .CNT_W(16)) dut (
    .stg_clk(stg_clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_rd_memory(ex_rd_memory), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_ena(pc_a), .ifid_ena(ifen_a), .ifid_x(ifx_a), .idex_ena(iden_a), .idex_x(idx_a),
    .exmem_ena(exen_a), .memwb_x(mwx_a), .mem_timeout_err(err_a),
    .stall_cycles(stall_a), .flush_count(flush_a)
  );

  pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(255), .CNT_W(16)) dut1 (
    .stg_clk(stg_clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_rd_memory(ex_rd_memory), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_ena(pc_b), .ifid_ena(ifen_b), .ifid_x(ifx_b), .idex_ena(iden_b), .idex_x(idx_b),
    .exmem_ena(exen_b), .memwb_x(mwx_b), .mem_timeout_err(err_b),
    .stall_cycles(stall_b), .flush_count(flush_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                     input logic [4:0] rd, input logic ld, input logic br, input logic req,
                     input logic rdy, input logic [6:0] ea, input logic [6:0] eb);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.ld = ld;
    v.br = br; v.req = req; v.rdy = rdy; v.exp_a = ea; v.exp_b = eb;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
    ex_rd = v.rd; ex_rd_memory = v.ld; ex_branch_taken = v.br;
    mem_req = v.req; mem_ready = v.rdy;
  endtask

  task automatic nop();
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rd = 0; ex_rd_memory = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    int exp_stall_a, exp_stall_b, exp_flush;
    exp_stall_a = 0; exp_stall_b = 0; exp_flush = 0;

    //  rs1 rs2 u1 u2 rd ld br req rdy  dut(3 bubbles)  dut1(1 bubble)
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, P_RUN, P_RUN);
    add(5, 0, 1, 0, 5, 1, 0, 0, 0, P_LU,  P_LU);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, P_LU,  P_RUN);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, P_LU,  P_RUN);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, P_RUN, P_RUN);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0, P_RUN, P_RUN);
    add(3, 9, 1, 1, 9, 1, 0, 0, 0, P_LU,  P_LU);
    add(3, 9, 1, 0, 9, 1, 0, 0, 0, P_LU,  P_RUN);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, P_BR,  P_BR);
    add(5, 0, 1, 0, 5, 1, 1, 0, 0, P_BR,  P_BR);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, P_RUN, P_RUN);
    for (int k = 0; k < 4; k++)
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, P_FRZ, P_FRZ);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, P_RUN, P_RUN);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, P_RUN, P_RUN);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, P_FRZ, P_FRZ);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1, P_BR,  P_BR);
    add(5, 0, 1, 0, 5, 1, 0, 0, 0, P_LU,  P_LU);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, P_FRZ, P_FRZ);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, P_FRZ, P_FRZ);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, P_LU,  P_RUN);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, P_LU,  P_RUN);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, P_RUN, P_RUN);
    add(5, 0, 1, 0, 5, 0, 0, 0, 0, P_RUN, P_RUN);

    reset = 1'b1;
    nop();
    @(posedge stg_clk); #1;
    chk("reset_out_a", out_a, P_RST);
    chk("reset_out_b", out_b, P_RST);
    chk("reset_err_a", err_a, 0);
    chk("reset_stall_a", stall_a, 0);
    chk("reset_flush_a", flush_a, 0);
    @(posedge stg_clk); #1;
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #2;
      chk($sformatf("row%0d_a", i), out_a, tbl[i].exp_a);
      chk($sformatf("row%0d_b", i), out_b, tbl[i].exp_b);
      if (!tbl[i].exp_a[6]) exp_stall_a++;
      if (!tbl[i].exp_b[6]) exp_stall_b++;
      if (tbl[i].exp_a == P_BR) exp_flush++;
      @(posedge stg_clk); #1;
    end
    chk("table_err_a", err_a, 0);

`ifdef HAZARD_STATS_EN
    chk("stall_cycles_a", stall_a, exp_stall_a);
    chk("stall_cycles_b", stall_b, exp_stall_b);
    chk("flush_count_a", flush_a, exp_flush);
    chk("flush_count_b", flush_b, exp_flush);
`else
    chk("stall_tied_a", stall_a, 0);
    chk("flush_tied_b", flush_b, 0);
`endif

    // Timeout: mem_ready held low; error must appear after the 8th wait cycle.
    reset = 1'b1;
    @(posedge stg_clk); #1;
    reset = 1'b0;
    nop();
    mem_req = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      #2;
      chk($sformatf("timeout_err_k%0d", k), err_a, (k >= 8) ? 1 : 0);
      chk($sformatf("timeout_frz_k%0d", k), out_a, P_FRZ);
      @(posedge stg_clk); #1;
    end
    chk("timeout_err_b", err_b, 0);
    mem_req = 1'b0;
    #2;
    chk("timeout_resume_out", out_a, P_RUN);
    chk("timeout_sticky0", err_a, 1);
    @(posedge stg_clk); #3;
    chk("timeout_sticky1", err_a, 1);
    reset = 1'b1;
    #1;
    chk("timeout_cleared", err_a, 0);
    @(posedge stg_clk); #1;
    reset = 1'b0;

    // Reset asserted in the middle of a load-use stall.
    id_rs1 = 5; id_rs1_used = 1; ex_rd = 5; ex_rd_memory = 1;
    #2;
    chk("lurst_lu", out_a, P_LU);
    @(posedge stg_clk); #1;
    nop();
    #2;
    chk("lurst_stall", out_a, P_LU);
    reset = 1'b1;
    #1;
    chk("lurst_async_a", out_a, P_RST);
    chk("lurst_async_b", out_b, P_RST);
    @(posedge stg_clk); #1;
    reset = 1'b0;
    #2;
    chk("lurst_run0", out_a, P_RUN);
    @(posedge stg_clk); #3;
    chk("lurst_run1", out_a, P_RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
